writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 122 ++++++++++++
 tb/tb_writeback_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: arbitrates ALU results and load responses (load first), formats load data,
// and drives a registered register-file write port plus a retired-instruction counter.
module writeback_stage #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset_N,
  input  logic                      i_Enable,
  // ALU result channel
  input  logic                      i_Alu_Valid,
  input  logic [REG_ADDR_WIDTH-1:0] i_Alu_Rd,
  input  logic [XLEN-1:0]           i_Alu_Data,
  output logic                      o_Alu_Ready,
  // Load response channel (raw aligned word plus byte offset)
  input  logic                      i_Load_Valid,
  input  logic [REG_ADDR_WIDTH-1:0] i_Load_Rd,
  input  logic [XLEN-1:0]           i_Load_Data,
  input  logic [2:0]                i_Load_Funct3,
  input  logic [1:0]                i_Load_Offset,
  output logic                      o_Load_Ready,
  // Register-file write port
  output logic                      o_Write_Enable,
  output logic [REG_ADDR_WIDTH-1:0] o_Write_Addr,
  output logic [XLEN-1:0]           o_Write_Data,
  output logic                      o_Load_Error,
  output logic [31:0]               o_Retired_Count
);

  logic                      we_q, we_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [XLEN-1:0]           data_q, data_d;
  logic                      err_q, err_d;
  logic [31:0]               cnt_q, cnt_d;

  logic                      load_acc, alu_acc;
  logic [7:0]                load_byte;
  logic [15:0]               load_half;
  logic [XLEN-1:0]           load_value;
  logic                      load_bad;

  // Readies: held low in reset so nothing is accepted while the stage is cleared.
  always_comb begin
    o_Load_Ready = i_Enable & i_Reset_N;
    o_Alu_Ready  = i_Enable & i_Reset_N & ~i_Load_Valid;
    load_acc     = i_Load_Valid & o_Load_Ready;
    alu_acc      = i_Alu_Valid & o_Alu_Ready;
  end

  // Load formatting: lane select, extension, and misalignment / illegal funct3 detection.
  always_comb begin
    load_byte  = i_Load_Data[8*i_Load_Offset +: 8];
    load_half  = i_Load_Data[16*i_Load_Offset[1] +: 16];
    load_value = i_Load_Data;
    load_bad   = 1'b0;
    case (i_Load_Funct3)
      3'b000: load_value = {{(XLEN-8){load_byte[7]}}, load_byte};
      3'b001: begin
        load_value = {{(XLEN-16){load_half[15]}}, load_half};
        load_bad   = i_Load_Offset[0];
      end
      3'b010: begin
        load_value = i_Load_Data;
        load_bad   = (i_Load_Offset != 2'd0);
      end
      3'b100: load_value = {{(XLEN-8){1'b0}}, load_byte};
      3'b101: begin
        load_value = {{(XLEN-16){1'b0}}, load_half};
        load_bad   = i_Load_Offset[0];
      end
      default: load_bad = 1'b1;
    endcase
  end

  // Next state: write/error pulses default low; address and data hold unless a commit occurs.
  always_comb begin
    we_d   = 1'b0;
    err_d  = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load_acc) begin
      if (load_bad) begin
        err_d = 1'b1;
      end else begin
        we_d   = (i_Load_Rd != '0);
        addr_d = i_Load_Rd;
        data_d = load_value;
        cnt_d  = cnt_q + 32'd1;
      end
    end else if (alu_acc) begin
      we_d   = (i_Alu_Rd != '0);
      addr_d = i_Alu_Rd;
      data_d = i_Alu_Data;
      cnt_d  = cnt_q + 32'd1;
    end
  end

  // State register; reset clears everything, discarding any in-flight acceptance.
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_Write_Enable  = we_q;
  assign o_Write_Addr    = addr_q;
  assign o_Write_Data    = data_q;
  assign o_Load_Error    = err_q;
  assign o_Retired_Count = cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed, table-driven bench for writeback_stage plus hand sequences for arbitration and reset.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        load_valid;
  logic [4:0]  load_rd;
  logic [31:0] load_data;
  logic [2:0]  load_f3;
  logic [1:0]  load_off;
  logic        load_ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        lerr;
  logic [31:0] rcount;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  writeback_stage #(.XLEN(32), .REG_ADDR_WIDTH(5)) dut (
    .i_Clock        (clk),
    .i_Reset_N      (rst_n),
    .i_Enable       (en),
    .i_Alu_Valid    (alu_valid),
    .i_Alu_Rd       (alu_rd),
    .i_Alu_Data     (alu_data),
    .o_Alu_Ready    (alu_ready),
    .i_Load_Valid   (load_valid),
    .i_Load_Rd      (load_rd),
    .i_Load_Data    (load_data),
    .i_Load_Funct3  (load_f3),
    .i_Load_Offset  (load_off),
    .o_Load_Ready   (load_ready),
    .o_Write_Enable (we),
    .o_Write_Addr   (waddr),
    .o_Write_Data   (wdata),
    .o_Load_Error   (lerr),
    .o_Retired_Count(rcount)
  );

  typedef struct {
    logic        en;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic        xlrdy;
    logic        xardy;
    logic        xwe;
    logic        xerr;
    logic        xinc;
    logic        xchk;   // check write address/data
    logic [4:0]  xaddr;
    logic [31:0] xdata;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid  = 1'b0;
    alu_rd     = '0;
    alu_data   = '0;
    load_valid = 1'b0;
    load_rd    = '0;
    load_data  = '0;
    load_f3    = '0;
    load_off   = '0;
  endtask

  function automatic vec_t mk(logic e, logic av, logic [4:0] ard, logic [31:0] ad, logic lv,
                              logic [4:0] lrd, logic [31:0] ld, logic [2:0] f3, logic [1:0] off,
                              logic xwe, logic xerr, logic xinc, logic xchk, logic [4:0] xa,
                              logic [31:0] xd);
    vec_t v;
    v.en = e; v.av = av; v.ard = ard; v.adata = ad; v.lv = lv; v.lrd = lrd; v.ldata = ld;
    v.f3 = f3; v.off = off; v.xwe = xwe; v.xerr = xerr; v.xinc = xinc; v.xchk = xchk;
    v.xaddr = xa; v.xdata = xd;
    v.xlrdy = e;
    v.xardy = e & ~lv;
    return v;
  endfunction

  initial begin
    // en av ard adata lv lrd ldata f3 off | we err inc chk addr data
    vecs[0]  = mk(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0, 1, 1, 5, 32'hDEADBEEF);
    vecs[1]  = mk(1, 0, 0, 0, 1, 3, 32'h00800000, 3'b000, 2, 1, 0, 1, 1, 3, 32'hFFFFFF80);
    vecs[2]  = mk(1, 0, 0, 0, 1, 3, 32'h00800000, 3'b100, 2, 1, 0, 1, 1, 3, 32'h00000080);
    vecs[3]  = mk(1, 0, 0, 0, 1, 6, 32'h80017FFF, 3'b001, 2, 1, 0, 1, 1, 6, 32'hFFFF8001);
    vecs[4]  = mk(1, 0, 0, 0, 1, 7, 32'h1234ABCD, 3'b101, 0, 1, 0, 1, 1, 7, 32'h0000ABCD);
    vecs[5]  = mk(1, 0, 0, 0, 1, 4, 32'h11223344, 3'b010, 1, 0, 1, 0, 1, 7, 32'h0000ABCD);
    vecs[6]  = mk(1, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[7]  = mk(1, 0, 0, 0, 1, 9, 32'h55555555, 3'b011, 0, 0, 1, 0, 0, 0, 0);
    vecs[8]  = mk(1, 0, 0, 0, 1, 9, 32'h55555555, 3'b001, 1, 0, 1, 0, 0, 0, 0);
    vecs[9]  = mk(1, 0, 0, 0, 1, 8, 32'h7F000000, 3'b000, 3, 1, 0, 1, 1, 8, 32'h0000007F);
    vecs[10] = mk(0, 1, 12, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 32'h0000007F);
    vecs[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 32'h0000007F);
  end

  initial begin
    exp_cnt = '0;
    rst_n   = 1'b0;
    en      = 1'b1;
    idle_inputs();
    #1;
    chk("reset_we", {31'd0, we}, 32'd0);
    chk("reset_addr", {27'd0, waddr}, 32'd0);
    chk("reset_data", wdata, 32'd0);
    chk("reset_err", {31'd0, lerr}, 32'd0);
    chk("reset_count", rcount, 32'd0);
    chk("reset_rdy", {30'd0, load_ready, alu_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      en         = vecs[i].en;
      alu_valid  = vecs[i].av;
      alu_rd     = vecs[i].ard;
      alu_data   = vecs[i].adata;
      load_valid = vecs[i].lv;
      load_rd    = vecs[i].lrd;
      load_data  = vecs[i].ldata;
      load_f3    = vecs[i].f3;
      load_off   = vecs[i].off;
      #1;
      chk($sformatf("v%0d_load_ready", i), {31'd0, load_ready}, {31'd0, vecs[i].xlrdy});
      chk($sformatf("v%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, vecs[i].xardy});
      @(posedge clk);
      #1;
      if (vecs[i].xinc) exp_cnt = exp_cnt + 32'd1;
      chk($sformatf("v%0d_we", i), {31'd0, we}, {31'd0, vecs[i].xwe});
      chk($sformatf("v%0d_err", i), {31'd0, lerr}, {31'd0, vecs[i].xerr});
      chk($sformatf("v%0d_count", i), rcount, exp_cnt);
      if (vecs[i].xchk) begin
        chk($sformatf("v%0d_addr", i), {27'd0, waddr}, {27'd0, vecs[i].xaddr});
        chk($sformatf("v%0d_data", i), wdata, vecs[i].xdata);
      end
    end

    // Simultaneous valids: load wins, ALU holds its fields and goes next.
    @(negedge clk);
    en = 1'b1;
    idle_inputs();
    alu_valid  = 1'b1; alu_rd  = 5'd1; alu_data  = 32'hA1A1A1A1;
    load_valid = 1'b1; load_rd = 5'd2; load_data = 32'hB2B2B2B2; load_f3 = 3'b010;
    #1;
    chk("sim_alu_ready_low", {31'd0, alu_ready}, 32'd0);
    chk("sim_load_ready", {31'd0, load_ready}, 32'd1);
    @(posedge clk);
    #1;
    exp_cnt = exp_cnt + 32'd1;
    chk("sim_c1_we", {31'd0, we}, 32'd1);
    chk("sim_c1_addr", {27'd0, waddr}, 32'd2);
    chk("sim_c1_data", wdata, 32'hB2B2B2B2);
    @(negedge clk);
    load_valid = 1'b0;
    #1;
    chk("sim_alu_ready_high", {31'd0, alu_ready}, 32'd1);
    @(posedge clk);
    #1;
    exp_cnt = exp_cnt + 32'd1;
    chk("sim_c2_we", {31'd0, we}, 32'd1);
    chk("sim_c2_addr", {27'd0, waddr}, 32'd1);
    chk("sim_c2_data", wdata, 32'hA1A1A1A1);
    chk("sim_c2_count", rcount, exp_cnt);
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #1;
    chk("sim_c3_we", {31'd0, we}, 32'd0);

    // Reset mid-stream right after an acceptance.
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99999999;
    @(posedge clk);
    #1;
    chk("rst_pre_we", {31'd0, we}, 32'd1);
    @(negedge clk);
    alu_rd = 5'd10; alu_data = 32'h10101010;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_we", {31'd0, we}, 32'd0);
    chk("rst_async_addr", {27'd0, waddr}, 32'd0);
    chk("rst_async_data", wdata, 32'd0);
    chk("rst_async_err", {31'd0, lerr}, 32'd0);
    chk("rst_async_count", rcount, 32'd0);
    chk("rst_async_rdy", {30'd0, load_ready, alu_ready}, 32'd0);
    exp_cnt = '0;
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_post%0d_we", k), {31'd0, we}, 32'd0);
      chk($sformatf("rst_post%0d_count", k), rcount, exp_cnt);
    end
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'h0BADF00D;
    @(posedge clk);
    #1;
    exp_cnt = exp_cnt + 32'd1;
    chk("rst_new_we", {31'd0, we}, 32'd1);
    chk("rst_new_addr", {27'd0, waddr}, 32'd11);
    chk("rst_new_count", rcount, exp_cnt);
    @(negedge clk);
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
